sfx_event_sequencer: RTL

Sits directly upstream of the AudioProcessingUnit. Turns raw, level-type collision flags from the game logic into clean, time-limited, mutually exclusive sound gates. The gates drive the APU's SheepDragonCollision, SwordDragonCollision and PlayerDragonCollision inputs. Durations are counted in video frames using the frame_end pulse, so effects last a fixed on-screen time. The APU sums its three channels, so this block guarantees that at most one gate is high at any time.

---
 rtl/sfx_pkg.sv | 26 ++
 rtl/sfx_edge_detect.sv | 22 ++
 rtl/sfx_event_sequencer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/sfx_pkg.sv
// rtl/sfx_pkg.sv - shared channel codes, state encoding and duration lookup for the sfx sequencer
package sfx_pkg;

    localparam logic [1:0] CH_NONE   = 2'd0;
    localparam logic [1:0] CH_SHEEP  = 2'd1;
    localparam logic [1:0] CH_SWORD  = 2'd2;
    localparam logic [1:0] CH_PLAYER = 2'd3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_COOL = 2'd2;

    // Channel codes double as priorities, so a numeric compare selects the winner.
    function automatic int unsigned ch_frames(input logic [1:0] ch,
                                              input int unsigned sheep,
                                              input int unsigned sword,
                                              input int unsigned player);
        case (ch)
            CH_SHEEP:  return sheep;
            CH_SWORD:  return sword;
            CH_PLAYER: return player;
            default:   return 0;
        endcase
    endfunction

endpackage

// File: rtl/sfx_edge_detect.sv
// rtl/sfx_edge_detect.sv - registered rising-edge detector whose history resets to 1
module sfx_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic hit,
    output logic rise
);

    logic hit_q;

    // History resets high so a level held through reset is not taken as an edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hit_q <= 1'b1;
        end else begin
            hit_q <= hit;
        end
    end

    assign rise = hit & ~hit_q;

endmodule

// File: rtl/sfx_event_sequencer.sv
// rtl/sfx_event_sequencer.sv - turns collision levels into exclusive, frame-timed APU sound gates
module sfx_event_sequencer
    import sfx_pkg::*;
#(
    parameter int unsigned FRAME_BITS      = 6,
    parameter int unsigned SHEEP_FRAMES    = 8,
    parameter int unsigned SWORD_FRAMES    = 12,
    parameter int unsigned PLAYER_FRAMES   = 30,
    parameter int unsigned COOLDOWN_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_end,
    input  logic       sheep_dragon_hit,
    input  logic       sword_dragon_hit,
    input  logic       player_dragon_hit,
    output logic       sheep_gate,
    output logic       sword_gate,
    output logic       player_gate,
    output logic [1:0] active_ch,
    output logic       busy
);

    localparam logic [FRAME_BITS-1:0] CNT_ONE   = FRAME_BITS'(1);
    localparam logic [FRAME_BITS-1:0] COOL_LOAD = FRAME_BITS'(COOLDOWN_FRAMES);

    logic                  sheep_edge, sword_edge, player_edge;
    logic [1:0]            win_ch;
    logic [FRAME_BITS-1:0] win_frames;
    logic                  take;
    logic [1:0]            state, nxt_state;
    logic [1:0]            last_ch, nxt_ch;
    logic [FRAME_BITS-1:0] cnt, nxt_cnt;

    sfx_edge_detect u_sheep_edge (
        .clk   (clk),
        .reset (reset),
        .hit   (sheep_dragon_hit),
        .rise  (sheep_edge)
    );

    sfx_edge_detect u_sword_edge (
        .clk   (clk),
        .reset (reset),
        .hit   (sword_dragon_hit),
        .rise  (sword_edge)
    );

    sfx_edge_detect u_player_edge (
        .clk   (clk),
        .reset (reset),
        .hit   (player_dragon_hit),
        .rise  (player_edge)
    );

    always_comb begin
        if (player_edge) begin
            win_ch = CH_PLAYER;
        end else if (sword_edge) begin
            win_ch = CH_SWORD;
        end else if (sheep_edge) begin
            win_ch = CH_SHEEP;
        end else begin
            win_ch = CH_NONE;
        end
    end

    assign win_frames = FRAME_BITS'(ch_frames(win_ch, SHEEP_FRAMES, SWORD_FRAMES, PLAYER_FRAMES));

    // last_ch is CH_NONE whenever idle, so the strict compare also covers a fresh start;
    // an equal channel only counts as a retrigger while actually playing.
    assign take = (win_ch != CH_NONE) &&
                  ((win_ch > last_ch) || ((state == ST_PLAY) && (win_ch == last_ch)));

    always_comb begin
        nxt_state = state;
        nxt_ch    = last_ch;
        nxt_cnt   = cnt;
        if (take) begin
            nxt_state = ST_PLAY;
            nxt_ch    = win_ch;
            nxt_cnt   = win_frames;
        end else if (frame_end && (state != ST_IDLE)) begin
            if (cnt == CNT_ONE) begin
                if ((state == ST_PLAY) && (COOLDOWN_FRAMES > 0)) begin
                    nxt_state = ST_COOL;
                    nxt_cnt   = COOL_LOAD;
                end else begin
                    nxt_state = ST_IDLE;
                    nxt_ch    = CH_NONE;
                    nxt_cnt   = '0;
                end
            end else if (cnt != '0) begin
                nxt_cnt = cnt - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            last_ch     <= CH_NONE;
            cnt         <= '0;
            sheep_gate  <= 1'b0;
            sword_gate  <= 1'b0;
            player_gate <= 1'b0;
            active_ch   <= CH_NONE;
            busy        <= 1'b0;
        end else begin
            state       <= nxt_state;
            last_ch     <= nxt_ch;
            cnt         <= nxt_cnt;
            sheep_gate  <= (nxt_state == ST_PLAY) && (nxt_ch == CH_SHEEP);
            sword_gate  <= (nxt_state == ST_PLAY) && (nxt_ch == CH_SWORD);
            player_gate <= (nxt_state == ST_PLAY) && (nxt_ch == CH_PLAYER);
            active_ch   <= (nxt_state == ST_PLAY) ? nxt_ch : CH_NONE;
            busy        <= (nxt_state != ST_IDLE);
        end
    end

endmodule
